// File: rtl/commit_marker_tracker.sv
// Phase-marker tracker on the ROB commit ports: decodes slti x0,x0,imm markers per lane,
// tracks open/closed phases with start stamps, and serializes events through a FWFT FIFO.

module commit_marker_decode (
  input  logic        valid,
  input  logic [31:0] inst,
  output logic        is_marker,
  output logic [3:0]  code
);
  // slti x0,x0,imm with imm[11:4]==0 and imm[3:0] in 0..13
  assign is_marker = valid && (inst[31:24] == 8'h00) && (inst[19:0] == 20'h02013)
                     && (inst[23:20] <= 4'd13);
  assign code      = inst[23:20];
endmodule

module commit_marker_tracker #(
  parameter int LANES      = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [LANES-1:0]      commit_valid,
  input  logic [32*LANES-1:0]   commit_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_code,
  output logic [CNT_W-1:0]      out_cycle,
  output logic [CNT_W-1:0]      out_duration,
  output logic [6:0]            phase_active,
  output logic                  overflow,
  output logic                  proto_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [3:0]       code;
    logic [CNT_W-1:0] cycle;
    logic [CNT_W-1:0] dur;
  } evt_t;

  logic [CNT_W-1:0] cnt_q;

  logic [LANES-1:0]      mk;
  logic [LANES-1:0][3:0] code;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    commit_marker_decode u_dec (
      .valid     (commit_valid[g]),
      .inst      (commit_inst[32*g +: 32]),
      .is_marker (mk[g]),
      .code      (code[g])
    );
  end

  // Phase state, chained through the lanes so same-cycle START/END pairs resolve in order.
  logic [6:0]                   act_q, act_d;
  logic [6:0][CNT_W-1:0]        start_q, start_d;
  logic [LANES-1:0][CNT_W-1:0]  dur;
  logic                         perr_d;
  logic [2:0]                   ph;

  always_comb begin
    act_d   = act_q;
    start_d = start_q;
    dur     = '0;
    perr_d  = 1'b0;
    ph      = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mk[i]) begin
        ph = code[i][3:1];
        if (!code[i][0]) begin
          if (act_d[ph]) perr_d = 1'b1;
          act_d[ph]   = 1'b1;
          start_d[ph] = cnt_q;
        end else if (act_d[ph]) begin
          dur[i]    = cnt_q - start_d[ph];
          act_d[ph] = 1'b0;
        end else begin
          perr_d = 1'b1;
        end
      end
    end
  end

  // FIFO push selection: free space uses the count at cycle start, pops are not credited.
  logic [PW-1:0]             wr_q, rd_q;
  logic [CW-1:0]             count_q, free, n_mk, n_push;
  logic [LANES-1:0][CW-1:0]  rank;
  logic [LANES-1:0]          push_en;
  logic                      drop, pop;

  always_comb begin
    free    = CW'(FIFO_DEPTH) - count_q;
    n_mk    = '0;
    n_push  = '0;
    rank    = '0;
    push_en = '0;
    for (int i = 0; i < LANES; i++) begin
      rank[i]    = n_mk;
      push_en[i] = mk[i] && (n_mk < free);
      if (mk[i])      n_mk   = n_mk + CW'(1);
      if (push_en[i]) n_push = n_push + CW'(1);
    end
    drop = |(mk & ~push_en);
  end

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  evt_t mem [FIFO_DEPTH];
  evt_t head;

  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++)
      if (!reset && push_en[i])
        mem[wr_q + rank[i][PW-1:0]] <= '{code: code[i], cycle: cnt_q, dur: dur[i]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      act_q     <= '0;
      start_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
      act_q   <= act_d;
      start_q <= start_d;
      wr_q    <= wr_q + n_push[PW-1:0];
      if (pop) rd_q <= rd_q + PW'(1);
      count_q <= count_q + n_push - CW'(pop);
      if (drop)   overflow  <= 1'b1;
      if (perr_d) proto_err <= 1'b1;
    end
  end

  assign head         = mem[rd_q];
  assign out_code     = out_valid ? head.code  : '0;
  assign out_cycle    = out_valid ? head.cycle : '0;
  assign out_duration = out_valid ? head.dur   : '0;
  assign phase_active = act_q;

endmodule
